// File: rtl/heartbeat_monitor_multi.sv
// Per-neighbour heartbeat monitor: per-channel request timers and miss counters,
// with due requests issued round-robin through a single registered valid/ready slot.
module heartbeat_monitor_multi #(
  parameter int NUM_NEIGHBORS               = 4,
  parameter int NODE_ID_WIDTH               = 8,
  parameter int MAX_HEARTBEAT_REQUEST_TIMER = 1000,
  parameter int MAX_MISS                    = 3
) (
  input  logic                                     nocclk,
  input  logic                                     rst_n,
  input  logic                                     in_enable,
  input  logic [NUM_NEIGHBORS-1:0]                 in_neighbor_valid,
  input  logic [NUM_NEIGHBORS*NODE_ID_WIDTH-1:0]   in_neighbor_node_id,
  input  logic                                     in_incoming_flit_valid,
  input  logic [NODE_ID_WIDTH-1:0]                 in_incoming_flit_node_id,
  output logic                                     out_request_valid,
  input  logic                                     in_request_ready,
  output logic [NODE_ID_WIDTH-1:0]                 out_request_node_id,
  output logic [$clog2(NUM_NEIGHBORS)-1:0]         out_request_index,
  output logic [NUM_NEIGHBORS-1:0]                 out_neighbor_alive,
  output logic [NUM_NEIGHBORS-1:0]                 out_timeout_pulse
);

  localparam int N  = NUM_NEIGHBORS;
  localparam int W  = NODE_ID_WIDTH;
  localparam int TW = $clog2(MAX_HEARTBEAT_REQUEST_TIMER);
  localparam int MW = $clog2(MAX_MISS + 1);
  localparam int IW = $clog2(NUM_NEIGHBORS);

  logic [TW-1:0] timer [N];
  logic [MW-1:0] miss  [N];
  logic [N-1:0]  pending;
  logic [N-1:0]  valid_q;
  logic [N-1:0]  match;
  logic [N-1:0]  expire;
  logic [N-1:0]  miss_full;
  logic [N-1:0]  cand;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel_idx;
  logic [W-1:0]  sel_id;
  logic          sel_found;
  logic          xfer;
  logic          drop;
  logic          slot_free;
  logic          load;

  always_comb begin
    match     = '0;
    expire    = '0;
    miss_full = '0;
    for (int unsigned i = 0; i < N; i++) begin
      match[i]     = in_incoming_flit_valid & in_neighbor_valid[i] &
                     (in_incoming_flit_node_id == in_neighbor_node_id[i*W +: W]);
      miss_full[i] = (miss[i] == MW'(MAX_MISS));
      expire[i]    = in_enable & in_neighbor_valid[i] & ~match[i] &
                     (timer[i] == TW'(MAX_HEARTBEAT_REQUEST_TIMER - 1));
    end
  end

  // A drop of the offered channel empties the slot and is never a transfer.
  assign drop      = out_request_valid & ~in_neighbor_valid[out_request_index];
  assign xfer      = out_request_valid & in_request_ready & ~drop;
  assign slot_free = ~out_request_valid | xfer | drop;
  assign cand      = pending & in_neighbor_valid;
  assign load      = slot_free & in_enable & sel_found;

  // Round-robin pick: smallest distance past rr_ptr wins.
  always_comb begin : rr_select
    int unsigned best_d;
    int unsigned d;
    best_d    = N;
    d         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      d = (i + N - 1 - 32'(rr_ptr)) % N;
      if (cand[i] && d < best_d) begin
        best_d    = d;
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_id    = in_neighbor_node_id[i*W +: W];
      end
    end
  end

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        timer[i] <= '0;
        miss[i]  <= '0;
      end
      pending             <= '0;
      valid_q             <= '0;
      out_neighbor_alive  <= '0;
      out_timeout_pulse   <= '0;
      out_request_valid   <= 1'b0;
      out_request_node_id <= '0;
      out_request_index   <= '0;
      rr_ptr              <= IW'(N - 1);
    end else begin
      valid_q <= in_neighbor_valid;
      for (int unsigned i = 0; i < N; i++) begin
        out_timeout_pulse[i] <= 1'b0;
        if (!in_neighbor_valid[i]) begin
          timer[i]              <= '0;
          miss[i]               <= '0;
          pending[i]            <= 1'b0;
          out_neighbor_alive[i] <= 1'b0;
        end else begin
          if (!valid_q[i])
            out_neighbor_alive[i] <= 1'b1;
          if (expire[i] && !miss_full[i])
            pending[i] <= 1'b1;
          else if (load && sel_idx == IW'(i))
            pending[i] <= 1'b0;
          if (match[i]) begin
            timer[i]              <= '0;
            miss[i]               <= '0;
            out_neighbor_alive[i] <= 1'b1;
          end else begin
            if (in_enable)
              timer[i] <= expire[i] ? '0 : timer[i] + TW'(1);
            if (expire[i] && miss_full[i]) begin
              out_neighbor_alive[i] <= 1'b0;
              out_timeout_pulse[i]  <= 1'b1;
              miss[i]               <= '0;
            end else if (xfer && out_request_index == IW'(i) && !miss_full[i]) begin
              miss[i] <= miss[i] + MW'(1);
            end
          end
        end
      end
      if (load) begin
        out_request_valid   <= 1'b1;
        out_request_node_id <= sel_id;
        out_request_index   <= sel_idx;
        rr_ptr              <= sel_idx;
      end else if (slot_free) begin
        out_request_valid <= 1'b0;
      end
    end
  end

endmodule
